// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - bus bundle between two requesters, a response consumer and the ALU share arbiter
// Purpose: groups both request channels, the tagged response channel and the status outputs.
// Signals:
//   req0_valid/req0_ready/req0_op[2:0]/req0_a[3:0]/req0_b[3:0]  requester 0 command channel
//   req1_valid/req1_ready/req1_op[2:0]/req1_a[3:0]/req1_b[3:0]  requester 1 command channel
//   rsp_valid/rsp_ready/rsp_id/rsp_result[3:0]/rsp_zero/rsp_ovf  response channel
//   busy, gnt0_cnt[CNT_W-1:0], gnt1_cnt[CNT_W-1:0]              status
// Modports: master = requesters + consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [3:0]       req0_a;
  logic [3:0]       req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [3:0]       req1_a;
  logic [3:0]       req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [3:0]       rsp_result;
  logic             rsp_zero;
  logic             rsp_ovf;
  logic             busy;
  logic [CNT_W-1:0] gnt0_cnt;
  logic [CNT_W-1:0] gnt1_cnt;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf,
    input  busy, gnt0_cnt, gnt1_cnt
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf,
    output busy, gnt0_cnt, gnt1_cnt
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one 4-bit ALU between two requesters
// Purpose: accepts one command at a time from two requesters, runs it through alu_4bit,
//   and returns a registered, requester-tagged response.
// alu_4bit ports: i_op[2:0], i_a[3:0], i_b[3:0] in; o_result[3:0], o_zero, o_ovf out.
// alu_share_arbiter ports: clk, rst_n (async, active-low), bus (alu_share_arbiter_if.slave).

module alu_4bit (
  input  logic [2:0] i_op,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_result,
  output logic       o_zero,
  output logic       o_ovf
);
  logic [3:0] w_sum;
  logic [3:0] w_diff;
  logic       w_add_ovf;
  logic       w_sub_ovf;

  assign w_sum     = i_a + i_b;
  assign w_diff    = i_a - i_b;
  // Signed overflow: operands' signs relate wrongly to the result sign.
  assign w_add_ovf = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
  assign w_sub_ovf = (i_a[3] != i_b[3]) && (w_diff[3] != i_a[3]);

  always_comb begin
    o_result = 4'd0;
    o_ovf    = 1'b0;
    case (i_op)
      3'b000: o_result = i_a & i_b;
      3'b001: o_result = i_a | i_b;
      3'b010: begin o_result = w_sum;  o_ovf = w_add_ovf; end
      3'b110: begin o_result = w_diff; o_ovf = w_sub_ovf; end
      // Sign of the difference corrected by overflow gives the true signed compare.
      3'b111: begin o_result = {3'b000, w_diff[3] ^ w_sub_ovf}; o_ovf = w_sub_ovf; end
      default: begin o_result = 4'd0; o_ovf = 1'b0; end
    endcase
  end

  assign o_zero = (o_result == 4'd0);
endmodule

module alu_share_arbiter #(
  parameter logic PRIO_INIT = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_prio;
  logic [2:0]       r_op;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [3:0]       r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_ovf;
  logic [CNT_W-1:0] r_gnt0;
  logic [CNT_W-1:0] r_gnt1;

  logic             w_gnt;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_done;
  logic             w_ready0;
  logic             w_ready1;
  logic [3:0]       w_result;
  logic             w_zero;
  logic             w_ovf;

  // Contention goes to r_prio; otherwise the single valid requester wins.
  assign w_gnt = (bus.req0_valid && bus.req1_valid) ? r_prio : bus.req1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_rsp_done = 1'b0;
    w_ready0   = 1'b0;
    w_ready1   = 1'b0;
    case (r_state)
      IDLE: begin
        // Ready is gated by rst_n so it stays low while reset is asserted.
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          w_accept = 1'b1;
          w_ready0 = ~w_gnt;
          w_ready1 = w_gnt;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        w_capture = 1'b1;
        w_next    = RESP;
      end
      RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_done = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The ALU only ever sees the latched command, never the live request inputs.
  alu_4bit u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio       <= PRIO_INIT;
      r_op         <= 3'd0;
      r_a          <= 4'd0;
      r_b          <= 4'd0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 4'd0;
      r_rsp_zero   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_gnt0       <= '0;
      r_gnt1       <= '0;
    end else begin
      if (w_accept) begin
        r_op <= w_gnt ? bus.req1_op : bus.req0_op;
        r_a  <= w_gnt ? bus.req1_a  : bus.req0_a;
        r_b  <= w_gnt ? bus.req1_b  : bus.req0_b;
        r_id <= w_gnt;
        if (!w_gnt && (r_gnt0 != {CNT_W{1'b1}})) r_gnt0 <= r_gnt0 + 1'b1;
        if (w_gnt && (r_gnt1 != {CNT_W{1'b1}}))  r_gnt1 <= r_gnt1 + 1'b1;
      end
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_id;
        r_rsp_result <= w_result;
        r_rsp_zero   <= w_zero;
        r_rsp_ovf    <= w_ovf;
      end
      // Favour the requester that lost the last grant.
      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        r_prio      <= ~r_id;
      end
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_ovf    = r_rsp_ovf;
  assign bus.busy       = (r_state != IDLE);
  assign bus.gnt0_cnt   = r_gnt0;
  assign bus.gnt1_cnt   = r_gnt1;
endmodule
